// File: rtl/aukv_mem_access.sv
// Memory stage of the RV32I pipeline: runs one req/ack data-bus access per load/store.
// Define AUKV_MISALIGN_CHK_EN to reject misaligned half/word accesses instead of aligning them down.
module aukv_mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_instr_valid,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_exe_res,
   input  logic        i_mem_en,
   input  logic        i_mem_we,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wr_data,
   input  logic [2:0]  i_load_type,
   input  logic [1:0]  i_store_type,
   input  logic        i_wb_data_sel,
   input  logic [4:0]  i_wb_reg_sel,
   input  logic        i_wb_we,
   output logic        o_dbus_req,
   output logic        o_dbus_we,
   output logic [31:0] o_dbus_addr,
   output logic [31:0] o_dbus_wdata,
   output logic [3:0]  o_dbus_be,
   input  logic        i_dbus_ack,
   input  logic [31:0] i_dbus_rdata,
   output logic        o_stall,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_reg_sel,
   output logic        o_wb_we,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic        o_bus_err,
   output logic        o_misaligned
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic        w_start;
   logic        w_timeout;
   logic        w_stall;
   logic        w_mis;

   size_t       w_size;
   logic        w_unsigned;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   // Request fields captured at accept and held stable for the whole access.
   logic        r_req;
   logic        r_dbus_we;
   logic [31:0] r_dbus_addr;
   logic [31:0] r_dbus_wdata;
   logic [3:0]  r_dbus_be;
   size_t       r_size;
   logic        r_unsigned;
   logic [1:0]  r_lane;
   logic [4:0]  r_rd;
   logic        r_rd_we;
   logic        r_wb_sel;
   logic [31:0] r_exe_res;
   logic [31:0] r_req_pc;
   logic [7:0]  r_tmo_cnt;

   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_reg_sel;
   logic        r_wb_we;
   logic        r_instr_valid;
   logic [31:0] r_pc;
   logic        r_bus_err;
   logic        r_misaligned;

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_result;

   assign w_lane = i_mem_addr[1:0];

   // Unused type codes fall through to word accesses.
   always_comb begin
      w_size = SZ_WORD;
      if (i_mem_we) begin
         case (i_store_type)
            2'd0:    w_size = SZ_BYTE;
            2'd1:    w_size = SZ_HALF;
            default: w_size = SZ_WORD;
         endcase
      end else begin
         case (i_load_type)
            3'd0, 3'd4: w_size = SZ_BYTE;
            3'd1, 3'd5: w_size = SZ_HALF;
            default:    w_size = SZ_WORD;
         endcase
      end
   end

   assign w_unsigned = ~i_mem_we & ((i_load_type == 3'd4) | (i_load_type == 3'd5));

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_be    = 4'h0;
      w_wdata = 32'h0;
      if (i_mem_we) begin
         case (w_size)
            SZ_BYTE: begin
               w_wdata = {4{i_mem_wr_data[7:0]}};
               w_be    = 4'b0001 << w_lane;
            end
            SZ_HALF: begin
               w_wdata = {2{i_mem_wr_data[15:0]}};
               w_be    = 4'b0011 << {w_lane[1], 1'b0};
            end
            default: begin
               w_wdata = i_mem_wr_data;
               w_be    = 4'hF;
            end
         endcase
      end
   end

`ifdef AUKV_MISALIGN_CHK_EN
   assign w_mis = (r_state == ST_IDLE) & i_mem_en & i_instr_valid & ~i_flush &
                  (((w_size == SZ_HALF) & w_lane[0]) | ((w_size == SZ_WORD) & (w_lane != 2'd0)));
`else
   assign w_mis = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_timeout    = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_mem_en & i_instr_valid & ~i_flush & ~w_mis) begin
               w_start      = 1'b1;
               w_stall      = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_dbus_ack) begin
               w_next_state = ST_IDLE;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_timeout    = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_byte = i_dbus_rdata[7:0];
      case (r_lane)
         2'd0: w_byte = i_dbus_rdata[7:0];
         2'd1: w_byte = i_dbus_rdata[15:8];
         2'd2: w_byte = i_dbus_rdata[23:16];
         2'd3: w_byte = i_dbus_rdata[31:24];
      endcase
   end

   assign w_half = r_lane[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];

   always_comb begin
      w_load_data = i_dbus_rdata;
      case (r_size)
         SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
         default: w_load_data = i_dbus_rdata;
      endcase
   end

   assign w_result = r_wb_sel ? w_load_data : r_exe_res;

   // NOTE: sequential state uses non-blocking assignments only; every register, including the
   // latched request fields, is cleared by reset so no output can leak stale data after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_req         <= 1'b0;
         r_dbus_we     <= 1'b0;
         r_dbus_addr   <= 32'h0;
         r_dbus_wdata  <= 32'h0;
         r_dbus_be     <= 4'h0;
         r_size        <= SZ_BYTE;
         r_unsigned    <= 1'b0;
         r_lane        <= 2'd0;
         r_rd          <= 5'd0;
         r_rd_we       <= 1'b0;
         r_wb_sel      <= 1'b0;
         r_exe_res     <= 32'h0;
         r_req_pc      <= 32'h0;
         r_tmo_cnt     <= 8'd0;
         r_wb_data     <= 32'h0;
         r_wb_reg_sel  <= 5'd0;
         r_wb_we       <= 1'b0;
         r_instr_valid <= 1'b0;
         r_pc          <= 32'h0;
         r_bus_err     <= 1'b0;
         r_misaligned  <= 1'b0;
      end else begin
         r_bus_err    <= 1'b0;
         r_misaligned <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_req         <= 1'b1;
                  r_dbus_we     <= i_mem_we;
                  r_dbus_addr   <= {i_mem_addr[31:2], 2'b00};
                  r_dbus_wdata  <= w_wdata;
                  r_dbus_be     <= w_be;
                  r_size        <= w_size;
                  r_unsigned    <= w_unsigned;
                  r_lane        <= w_lane;
                  r_rd          <= i_wb_reg_sel;
                  r_rd_we       <= i_wb_we;
                  r_wb_sel      <= i_wb_data_sel;
                  r_exe_res     <= i_exe_res;
                  r_req_pc      <= i_pc;
                  r_tmo_cnt     <= 8'd0;
                  r_wb_we       <= 1'b0;
                  r_instr_valid <= 1'b0;
               end else begin
                  // Passthrough; a rejected misaligned access retires without writing rd.
                  r_wb_data     <= i_exe_res;
                  r_wb_reg_sel  <= i_wb_reg_sel;
                  r_pc          <= i_pc;
                  r_instr_valid <= i_instr_valid & ~i_flush;
                  r_wb_we       <= i_wb_we & i_instr_valid & ~i_flush & ~w_mis;
                  r_misaligned  <= w_mis;
               end
            end
            ST_BUSY: begin
               if (i_dbus_ack) begin
                  r_req         <= 1'b0;
                  r_wb_data     <= w_result;
                  r_wb_reg_sel  <= r_rd;
                  r_pc          <= r_req_pc;
                  r_instr_valid <= 1'b1;
                  r_wb_we       <= r_rd_we & ~r_dbus_we;
               end else if (w_timeout) begin
                  r_req         <= 1'b0;
                  r_bus_err     <= 1'b1;
                  r_wb_reg_sel  <= r_rd;
                  r_pc          <= r_req_pc;
                  r_instr_valid <= 1'b1;
                  r_wb_we       <= 1'b0;
               end else begin
                  r_wb_we       <= 1'b0;
                  r_instr_valid <= 1'b0;
                  if (r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign o_dbus_req    = r_req;
   assign o_dbus_we     = r_dbus_we;
   assign o_dbus_addr   = r_dbus_addr;
   assign o_dbus_wdata  = r_dbus_wdata;
   assign o_dbus_be     = r_dbus_be;
   assign o_stall       = w_stall;
   assign o_wb_data     = r_wb_data;
   assign o_wb_reg_sel  = r_wb_reg_sel;
   assign o_wb_we       = r_wb_we;
   assign o_instr_valid = r_instr_valid;
   assign o_pc          = r_pc;
   assign o_bus_err     = r_bus_err;
   assign o_misaligned  = r_misaligned;

endmodule

// File: tb/tb_aukv_mem_access.sv
// Randomized self-checking bench for aukv_mem_access against a transaction-level reference model.
module tb_aukv_mem_access;

   localparam int TMO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_flush;
   logic        i_instr_valid;
   logic [31:0] i_pc;
   logic [31:0] i_exe_res;
   logic        i_mem_en;
   logic        i_mem_we;
   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wr_data;
   logic [2:0]  i_load_type;
   logic [1:0]  i_store_type;
   logic        i_wb_data_sel;
   logic [4:0]  i_wb_reg_sel;
   logic        i_wb_we;
   logic        o_dbus_req;
   logic        o_dbus_we;
   logic [31:0] o_dbus_addr;
   logic [31:0] o_dbus_wdata;
   logic [3:0]  o_dbus_be;
   logic        i_dbus_ack;
   logic [31:0] i_dbus_rdata;
   logic        o_stall;
   logic [31:0] o_wb_data;
   logic [4:0]  o_wb_reg_sel;
   logic        o_wb_we;
   logic        o_instr_valid;
   logic [31:0] o_pc;
   logic        o_bus_err;
   logic        o_misaligned;

   int n_vec = 0;
   int n_err = 0;

   aukv_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_instr_valid(i_instr_valid),
      .i_pc(i_pc), .i_exe_res(i_exe_res), .i_mem_en(i_mem_en), .i_mem_we(i_mem_we),
      .i_mem_addr(i_mem_addr), .i_mem_wr_data(i_mem_wr_data), .i_load_type(i_load_type),
      .i_store_type(i_store_type), .i_wb_data_sel(i_wb_data_sel), .i_wb_reg_sel(i_wb_reg_sel),
      .i_wb_we(i_wb_we), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
      .o_dbus_addr(o_dbus_addr), .o_dbus_wdata(o_dbus_wdata), .o_dbus_be(o_dbus_be),
      .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata), .o_stall(o_stall),
      .o_wb_data(o_wb_data), .o_wb_reg_sel(o_wb_reg_sel), .o_wb_we(o_wb_we),
      .o_instr_valid(o_instr_valid), .o_pc(o_pc), .o_bus_err(o_bus_err),
      .o_misaligned(o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Access size in bytes; unused codes behave as word accesses.
   function automatic int size_of(input logic we, input logic [2:0] lt, input logic [1:0] st);
      if (we) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
      if (lt == 3'd0 || lt == 3'd4) return 1;
      if (lt == 3'd1 || lt == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic is_mis(input int sz, input logic [31:0] addr);
`ifdef AUKV_MISALIGN_CHK_EN
      return (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] exp_be(input logic we, input int sz, input logic [31:0] addr);
      int a = int'(addr % 4);
      if (!we) return 4'h0;
      if (sz == 1) return 4'(1 << a);
      if (sz == 2) return (a >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
      if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input int sz, input logic [2:0] lt,
                                            input logic [31:0] addr, input logic [31:0] rd);
      int a = int'(addr % 4);
      logic [31:0] v;
      if (sz == 1) begin
         v = (rd >> (8 * a)) & 32'hFF;
         if (lt == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = (rd >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
         if (lt == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_nop();
      i_flush       = 1'b0;
      i_instr_valid = 1'b0;
      i_mem_en      = 1'b0;
      i_mem_we      = 1'b0;
      i_pc          = 32'h0;
      i_exe_res     = 32'h0;
      i_mem_addr    = 32'h0;
      i_mem_wr_data = 32'h0;
      i_load_type   = 3'd0;
      i_store_type  = 2'd0;
      i_wb_data_sel = 1'b0;
      i_wb_reg_sel  = 5'd0;
      i_wb_we       = 1'b0;
      i_dbus_ack    = 1'b0;
      i_dbus_rdata  = 32'h0;
   endtask

   // Non-memory instruction, or a memory instruction killed by flush in the same cycle.
   task automatic run_plain(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd,
                            input logic we, input logic mem, input logic flush);
      i_instr_valid = 1'b1;
      i_mem_en      = mem;
      i_mem_we      = 1'($urandom_range(0, 1));
      i_mem_addr    = $urandom;
      i_flush       = flush;
      i_pc          = pc;
      i_exe_res     = res;
      i_wb_reg_sel  = rd;
      i_wb_we       = we;
      #1;
      check("plain_stall", 32'(o_stall), 32'd0);
      cyc();
      drive_nop();
      check("plain_req", 32'(o_dbus_req), 32'd0);
      check("plain_valid", 32'(o_instr_valid), 32'(!flush));
      check("plain_we", 32'(o_wb_we), 32'(we && !flush));
      if (!flush) begin
         check("plain_data", o_wb_data, res);
         check("plain_rd", 32'(o_wb_reg_sel), 32'(rd));
         check("plain_pc", o_pc, pc);
      end
   endtask

   // One load/store; delay = busy cycles before ack, delay >= TMO means the bus never answers.
   task automatic run_mem(input logic [31:0] pc, input logic we, input logic [2:0] lt,
                          input logic [1:0] st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rd_we, input int delay,
                          input logic [31:0] rdata);
      int   sz  = size_of(we, lt, st);
      logic mis = is_mis(sz, addr);
      logic acked = 1'b0;
      i_instr_valid = 1'b1;
      i_mem_en      = 1'b1;
      i_mem_we      = we;
      i_load_type   = lt;
      i_store_type  = st;
      i_mem_addr    = addr;
      i_mem_wr_data = wd;
      i_wb_data_sel = !we;
      i_wb_reg_sel  = rd;
      i_wb_we       = rd_we;
      i_exe_res     = $urandom;
      i_pc          = pc;
      #1;
      check("acc_stall", 32'(o_stall), 32'(!mis));
      cyc();
      if (mis) begin
         drive_nop();
         check("mis_pulse", 32'(o_misaligned), 32'd1);
         check("mis_req", 32'(o_dbus_req), 32'd0);
         check("mis_valid", 32'(o_instr_valid), 32'd1);
         check("mis_we", 32'(o_wb_we), 32'd0);
         check("mis_pc", o_pc, pc);
         cyc();
         check("mis_one_cycle", 32'(o_misaligned), 32'd0);
         return;
      end
      check("req_up", 32'(o_dbus_req), 32'd1);
      check("req_we", 32'(o_dbus_we), 32'(we));
      check("req_addr", o_dbus_addr, addr & 32'hFFFF_FFFC);
      check("req_be", 32'(o_dbus_be), 32'(exp_be(we, sz, addr)));
      if (we) check("req_wdata", o_dbus_wdata, exp_wdata(sz, wd));
      check("stall_bubble_valid", 32'(o_instr_valid), 32'd0);
      check("stall_bubble_we", 32'(o_wb_we), 32'd0);
      for (int k = 0; k < TMO; k++) begin
         i_flush      = 1'($urandom_range(0, 1));
         i_dbus_rdata = $urandom;
         if (k == delay) begin
            i_dbus_ack   = 1'b1;
            i_dbus_rdata = rdata;
            #1;
            check("ack_stall", 32'(o_stall), 32'd0);
            cyc();
            acked = 1'b1;
            break;
         end
         #1;
         check("busy_req", 32'(o_dbus_req), 32'd1);
         check("busy_addr", o_dbus_addr, addr & 32'hFFFF_FFFC);
         check("busy_stall", 32'(o_stall), 32'(k != TMO - 1));
         cyc();
      end
      drive_nop();
      if (acked) begin
         check("done_req", 32'(o_dbus_req), 32'd0);
         check("done_valid", 32'(o_instr_valid), 32'd1);
         check("done_we", 32'(o_wb_we), 32'(rd_we && !we));
         check("done_rd", 32'(o_wb_reg_sel), 32'(rd));
         check("done_pc", o_pc, pc);
         check("done_err", 32'(o_bus_err), 32'd0);
         if (!we) check("load_data", o_wb_data, exp_load(sz, lt, addr, rdata));
      end else begin
         check("tmo_err", 32'(o_bus_err), 32'd1);
         check("tmo_req", 32'(o_dbus_req), 32'd0);
         check("tmo_we", 32'(o_wb_we), 32'd0);
         #1;
         check("tmo_stall", 32'(o_stall), 32'd0);
         cyc();
         check("tmo_one_cycle", 32'(o_bus_err), 32'd0);
      end
   endtask

   initial begin
      drive_nop();
      i_rst = 1'b1;
      #12;
      check("rst_req", 32'(o_dbus_req), 32'd0);
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_wb", o_wb_data | o_pc | 32'(o_wb_reg_sel), 32'd0);
      check("rst_flags", 32'({o_wb_we, o_instr_valid, o_bus_err, o_misaligned, o_dbus_we}), 32'd0);
      i_rst = 1'b0;
      cyc();

      run_mem(32'h0000_1000, 1'b0, 3'd0, 2'd0, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 3, 32'h80FF_FF00);
      run_mem(32'h0000_1004, 1'b1, 3'd0, 2'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd6, 1'b1, 0, 32'h0);
      run_plain(32'h0000_1008, 32'h0000_0055, 5'd7, 1'b1, 1'b0, 1'b0);
      run_mem(32'h0000_100C, 1'b0, 3'd2, 2'd0, 32'h0000_0300, 32'h0, 5'd8, 1'b1, TMO, 32'h0);
      run_mem(32'h0000_1010, 1'b0, 3'd2, 2'd0, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1, 32'hCAFE_F00D);
      run_mem(32'h0000_1014, 1'b0, 3'd5, 2'd0, 32'h0000_0402, 32'h0, 5'd10, 1'b1, 0, 32'h9876_5432);
      run_plain(32'h0000_1018, 32'h0000_00AA, 5'd11, 1'b1, 1'b1, 1'b1);

      // Reset while an access is outstanding must drop the request immediately.
      i_instr_valid = 1'b1;
      i_mem_en      = 1'b1;
      i_load_type   = 3'd2;
      i_mem_addr    = 32'h0000_0500;
      i_wb_data_sel = 1'b1;
      i_wb_we       = 1'b1;
      cyc();
      check("pre_rst_req", 32'(o_dbus_req), 32'd1);
      drive_nop();
      i_rst = 1'b1;
      #1;
      check("mid_rst_req", 32'(o_dbus_req), 32'd0);
      check("mid_rst_stall", 32'(o_stall), 32'd0);
      check("mid_rst_outs", o_wb_data | o_pc | o_dbus_addr | 32'(o_dbus_be), 32'd0);
      check("mid_rst_flags", 32'({o_wb_we, o_instr_valid, o_bus_err, o_misaligned}), 32'd0);
      cyc();
      #2;
      i_rst = 1'b0;
      cyc();

      for (int n = 0; n < 200; n++) begin
         int kind = $urandom_range(0, 9);
         if (kind < 3) begin
            run_plain($urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end else if (kind == 3) begin
            run_plain($urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1);
         end else begin
            run_mem($urandom, 1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), $urandom,
                    $urandom, 5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, TMO),
                    $urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
